// File: rtl/qspim_host_if.sv
// Wishbone classic slave-side bundle for the QSPI host bridge.
// Combinational grouping only, no latency.
// No backpressure of its own; the bridge stalls the master by withholding ack.
interface qspim_host_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/qspim_host.sv
// Wishbone-to-QSPI master: one Wishbone cycle becomes one cmd/addr/[dummy]/data frame.
// Latency: ack at 1 + 2*CLK_DIV*N cycles after accept (N = 18 write, 18+DUMMY_CYC read).
// Backpressure: master is stalled until ack/err; inputs ignored until the frame is done.
// Optional macro QSPIM_SEL_CHK_EN: writes with partial byte enables are rejected with err.
module qspim_host #(
  parameter int         CLK_DIV   = 2,
  parameter int         DUMMY_CYC = 4,
  parameter logic [7:0] CMD_WR    = 8'h02,
  parameter logic [7:0] CMD_RD    = 8'h0B
) (
  input  logic             sys_clk,
  input  logic             reset,
  qspim_host_if.slave      wbs,
  output logic             sclk,
  output logic             ssn,
  output logic [3:0]       sdout,
  output logic             sdout_oen,
  input  logic [3:0]       sdin
);

  typedef enum logic [2:0] {IDLE, CMD, ADR, DUMMY, WDATA, RDATA, DONE} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam int         DUMMY_L    = (DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0;
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_L);

  state_t      state, state_nxt;
  logic        started;     // ssn low: frame on the wire
  logic        sclk_r;
  logic [7:0]  div_cnt;
  logic [3:0]  nib_cnt;     // SCK period index inside the current state
  logic        we_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;
  logic [31:0] rd_sh;
  logic [31:0] dat_o_r;
  logic        done_pulse;
  logic        sel_err_r;

  logic        req;
  logic        run;
  logic        tick;
  logic        sck_fall;
  logic        sck_rise;
  logic [7:0]  cmd_byte;
  logic [31:0] adr_sh;
  logic [31:0] dat_sh;

  assign req      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  // The divider runs while the frame is on the wire and during the ssn-high guard in DONE.
  assign run      = started | (state == DONE);
  assign tick     = run & (div_cnt == DIV_LAST);
  assign sck_fall = tick & sclk_r;
  assign sck_rise = tick & ~sclk_r;
  assign cmd_byte = we_r ? CMD_WR : CMD_RD;
  assign adr_sh   = adr_r << {nib_cnt[2:0], 2'b00};
  assign dat_sh   = dat_r << {nib_cnt[2:0], 2'b00};

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: every phase ends on the SCK fall that closes its last period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req) state_nxt = CMD;
      CMD: begin
        if (!started && sel_err_r)             state_nxt = DONE;
        else if (sck_fall && nib_cnt == 4'd1)  state_nxt = ADR;
      end
      ADR: begin
        if (sck_fall && nib_cnt == 4'd7)
          state_nxt = we_r ? WDATA : ((DUMMY_CYC == 0) ? RDATA : DUMMY);
      end
      DUMMY: if (sck_fall && nib_cnt == DUMMY_LAST) state_nxt = RDATA;
      WDATA: if (sck_fall && nib_cnt == 4'd7)       state_nxt = DONE;
      RDATA: if (sck_fall && nib_cnt == 4'd7)       state_nxt = DONE;
      DONE:  if (tick && nib_cnt == 4'd1)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch, SCK divider, period counter, read shifter.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      started    <= 1'b0;
      sclk_r     <= 1'b0;
      div_cnt    <= 8'd0;
      nib_cnt    <= 4'd0;
      we_r       <= 1'b0;
      adr_r      <= 32'd0;
      dat_r      <= 32'd0;
      rd_sh      <= 32'd0;
      dat_o_r    <= 32'd0;
      done_pulse <= 1'b0;
      sel_err_r  <= 1'b0;
    end else begin
      done_pulse <= (state != DONE) && (state_nxt == DONE);
      // ssn drops one cycle after accept, so the first CMD cycle stays deselected.
      started    <= (state != IDLE) && (state_nxt != IDLE) && (state_nxt != DONE);

      if (!run || tick) div_cnt <= 8'd0;
      else              div_cnt <= div_cnt + 8'd1;

      if (!started)  sclk_r <= 1'b0;
      else if (tick) sclk_r <= ~sclk_r;

      if (state_nxt != state)                     nib_cnt <= 4'd0;
      else if ((state == DONE) ? tick : sck_fall) nib_cnt <= nib_cnt + 4'd1;

      if (state == IDLE && req) begin
        we_r  <= wbs.wbs_we_i;
        adr_r <= wbs.wbs_adr_i;
        dat_r <= wbs.wbs_dat_i;
`ifdef QSPIM_SEL_CHK_EN
        sel_err_r <= wbs.wbs_we_i && (wbs.wbs_sel_i != 4'hF);
`else
        sel_err_r <= 1'b0;
`endif
      end

      if (state == RDATA && sck_rise)            rd_sh   <= {rd_sh[27:0], sdin};
      if (state == RDATA && state_nxt == DONE)   dat_o_r <= rd_sh;
    end
  end

`ifndef QSPIM_SEL_CHK_EN
  logic unused_sel;
  assign unused_sel = ^wbs.wbs_sel_i;
`endif

  // Outputs: bus pins and Wishbone completion derived from registered state.
  always_comb begin
    ssn           = ~started;
    sclk          = sclk_r;
    sdout         = 4'd0;
    sdout_oen     = 1'b1;
    wbs.wbs_ack_o = done_pulse & ~sel_err_r;
    wbs.wbs_err_o = done_pulse &  sel_err_r;
    if (started) begin
      case (state)
        CMD: begin
          sdout_oen = 1'b0;
          sdout     = nib_cnt[0] ? cmd_byte[3:0] : cmd_byte[7:4];
        end
        ADR: begin
          sdout_oen = 1'b0;
          sdout     = adr_sh[31:28];
        end
        WDATA: begin
          sdout_oen = 1'b0;
          sdout     = dat_sh[31:28];
        end
        default: begin
          sdout_oen = 1'b1;
          sdout     = 4'd0;
        end
      endcase
    end
  end

  assign wbs.wbs_dat_o = dat_o_r;

endmodule

// File: tb/tb_qspim_host.sv
// Directed bench for qspim_host: vector table of Wishbone requests plus
// hand-written sequences for back-to-back requests and reset mid-frame.
module tb_qspim_host;
  localparam int D   = 2;
  localparam int DUM = 4;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       sclk, ssn, sdout_oen;
  logic [3:0] sdout;
  logic [3:0] sdin;

  qspim_host_if wb ();

  qspim_host #(.CLK_DIV(D), .DUMMY_CYC(DUM), .CMD_WR(8'h02), .CMD_RD(8'h0B)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .wbs       (wb),
    .sclk      (sclk),
    .ssn       (ssn),
    .sdout     (sdout),
    .sdout_oen (sdout_oen),
    .sdin      (sdin)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rword;
    bit          drop;
    bit          exp_err;
    int          exp_done;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t       tbl [5];
  int         n_chk = 0;
  int         n_err = 0;
  int         both_cnt = 0;
  logic [3:0] nib_q [32];
  logic       oen_q [32];

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on a negedge; cycle 0 is the next posedge. Acts as the QSPI slave for reads.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rword, input bit hold,
                         input bit drop, output int ack_cyc, output int err_cyc,
                         output int fall_cyc, output int rise_cyc, output int ack_w,
                         output int n_rise);
    logic        prev_sclk, prev_ssn, seen;
    logic [31:0] t;
    int          err_w;
    wb.wbs_cyc_i = 1'b1;  wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;   wb.wbs_sel_i = sel;
    sdin = 4'd0;
    ack_cyc = -1; err_cyc = -1; fall_cyc = -1; rise_cyc = -1;
    ack_w = 0; err_w = 0; n_rise = 0; seen = 1'b0;
    prev_sclk = sclk; prev_ssn = ssn;
    for (int c = 0; c < 400; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (drop && c == 5) begin
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
      end
      if (!ssn && prev_ssn && fall_cyc < 0) fall_cyc = c;
      if (sclk && !prev_sclk) begin
        if (rise_cyc < 0) rise_cyc = c;
        if (n_rise < 32) begin
          nib_q[n_rise] = sdout;
          oen_q[n_rise] = sdout_oen;
        end
        n_rise++;
        if (n_rise >= 10 + DUM && n_rise < 18 + DUM) begin
          t    = rword << (4 * (n_rise - 10 - DUM));
          sdin = t[31:28];
        end else begin
          sdin = 4'd0;
        end
      end
      if (wb.wbs_ack_o && wb.wbs_err_o) both_cnt++;
      if (seen && !wb.wbs_ack_o && !wb.wbs_err_o) break;
      if (wb.wbs_ack_o) begin
        if (ack_cyc < 0) ack_cyc = c;
        ack_w++;
      end
      if (wb.wbs_err_o) begin
        if (err_cyc < 0) err_cyc = c;
        err_w++;
      end
      if (wb.wbs_ack_o || wb.wbs_err_o) begin
        seen = 1'b1;
        if (hold) break;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
      end
      prev_sclk = sclk;
      prev_ssn  = ssn;
    end
    if (err_w > 1) ack_w = ack_w + 100;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    int          ack_cyc, err_cyc, fall_cyc, rise_cyc, ack_w, n_rise, nn;
    logic [71:0] frame, t;
    run_txn(v.we, v.adr, v.dat, v.sel, v.rword, 1'b0, v.drop,
            ack_cyc, err_cyc, fall_cyc, rise_cyc, ack_w, n_rise);
    if (v.exp_err) begin
      chk_int({tag, " err_cyc"}, err_cyc, v.exp_done);
      chk_int({tag, " ack_cyc"}, ack_cyc, -1);
      chk_int({tag, " ssn_fall"}, fall_cyc, -1);
      chk_int({tag, " rises"}, n_rise, 0);
    end else begin
      chk_int({tag, " ack_cyc"}, ack_cyc, v.exp_done);
      chk_int({tag, " ack_width"}, ack_w, 1);
      chk_int({tag, " err_cyc"}, err_cyc, -1);
      chk_int({tag, " ssn_fall"}, fall_cyc, 1);
      chk_int({tag, " first_rise"}, rise_cyc, 1 + D);
      chk_int({tag, " rises"}, n_rise, v.we ? 18 : 18 + DUM);
      frame = v.we ? {8'h02, v.adr, v.dat} : {8'h0B, v.adr, 32'h0};
      nn    = v.we ? 18 : 10;
      for (int i = 0; i < nn; i++) begin
        t = frame << (4 * i);
        chk_val($sformatf("%s nibble%0d", tag, i), {28'd0, nib_q[i]}, {28'd0, t[71:68]});
      end
      if (!v.we) begin
        chk_val({tag, " oen_last_adr"}, {31'd0, oen_q[9]}, 32'd0);
        chk_val({tag, " oen_dummy"}, {31'd0, oen_q[10]}, 32'd1);
      end
    end
    chk_val({tag, " dat_o"}, wb.wbs_dat_o, v.exp_dat);
    repeat (8) @(negedge sys_clk);
  endtask

  initial begin
    int a1, e1, f1, r1, w1, n1, a2, e2, f2, r2, w2, n2, bad;
    logic ssn_mid;
    reset = 1'b1;
    sdin  = 4'd0;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0; wb.wbs_sel_i = 4'h0;
    repeat (3) @(negedge sys_clk);
    chk_val("reset ssn", {31'd0, ssn}, 32'd1);
    chk_val("reset sclk", {31'd0, sclk}, 32'd0);
    chk_val("reset sdout", {28'd0, sdout}, 32'd0);
    chk_val("reset oen", {31'd0, sdout_oen}, 32'd1);
    chk_val("reset ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk_val("reset err", {31'd0, wb.wbs_err_o}, 32'd0);
    chk_val("reset dat_o", wb.wbs_dat_o, 32'd0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (ssn !== 1'b1 || sclk !== 1'b0 || sdout_oen !== 1'b1 || wb.wbs_ack_o !== 1'b0) bad++;
    end
    chk_int("idle bad_cycles", bad, 0);

    tbl[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0, 73, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 89, 32'h1234_5678};
    tbl[2] = '{1'b1, 32'hA5A5_0F0F, 32'h0123_4567, 4'hF, 32'h0, 1'b1, 1'b0, 73, 32'h1234_5678};
    tbl[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 89, 32'hCAFE_F00D};
`ifdef QSPIM_SEL_CHK_EN
    tbl[4] = '{1'b1, 32'h0000_0100, 32'h55AA_55AA, 4'h3, 32'h0, 1'b0, 1'b1, 1, 32'hCAFE_F00D};
`else
    tbl[4] = '{1'b1, 32'h0000_0100, 32'h55AA_55AA, 4'h3, 32'h0, 1'b0, 1'b0, 73, 32'hCAFE_F00D};
`endif
    for (int i = 0; i < 5; i++) check_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: stb held across the first ack, inputs switch to a read.
    run_txn(1'b1, 32'h80, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b1, 1'b0, a1, e1, f1, r1, w1, n1);
    chk_int("b2b first ack_cyc", a1, 73);
    run_txn(1'b0, 32'h80, 32'h0, 4'hF, 32'h89AB_CDEF, 1'b0, 1'b0, a2, e2, f2, r2, w2, n2);
    chk_int("b2b gap_ok", (f2 >= 2 * D) ? 1 : 0, 1);
    chk_int("b2b read latency", a2 - f2, 2 * D * (18 + DUM));
    chk_int("b2b read ack_width", w2, 1);
    chk_val("b2b read dat_o", wb.wbs_dat_o, 32'h89AB_CDEF);
    repeat (8) @(negedge sys_clk);

    // Reset at cycle 30 of a write frame.
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = 32'h40; wb.wbs_dat_i = 32'h1111_2222; wb.wbs_sel_i = 4'hF;
    for (int c = 0; c <= 30; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    ssn_mid = ssn;
    chk_val("rst_mid frame_active", {31'd0, ssn_mid}, 32'd0);
    reset = 1'b1;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_val("rst_mid ssn", {31'd0, ssn}, 32'd1);
    chk_val("rst_mid sclk", {31'd0, sclk}, 32'd0);
    chk_val("rst_mid oen", {31'd0, sdout_oen}, 32'd1);
    chk_val("rst_mid dat_o", wb.wbs_dat_o, 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sys_clk);
      if (wb.wbs_ack_o !== 1'b0 || ssn !== 1'b1) bad++;
    end
    chk_int("rst_mid no_ack", bad, 0);
    check_vec(tbl[0], "post_reset");

    chk_int("ack_and_err_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
